// File: rtl/hazard_if.sv
// -----------------------------------------------------------------------------
// hazard_if
// Purpose : bundles the pipeline-side signals exchanged with the hazard
//           controller: register specifiers and write enables from decode,
//           execute, memory and writeback, the branch and mul/div handshake,
//           and the forward/stall/flush controls plus the performance counters.
// Modports: master - pipeline side (drives register/control info, reads controls)
//           slave  - hazard controller side (reads pipeline info, drives controls)
// -----------------------------------------------------------------------------
interface hazard_if;
  // Decode / execute / memory / writeback register specifiers
  logic [4:0]  rs1_d, rs2_d;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [4:0]  rd_m, rd_w;
  logic        regwrite_m, regwrite_w;
  logic [1:0]  result_src_e;
  // Control flow and mul/div handshake
  logic        pc_src_e;
  logic        md_req_e;
  logic        md_done;
  // Controller outputs
  logic [1:0]  forward_a_e, forward_b_e;
  logic        stall_f, stall_d, stall_e;
  logic        flush_d, flush_e, flush_m;
  logic        md_start;
  logic        md_error;
  logic [31:0] stall_count, flush_count;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output regwrite_m, regwrite_w, result_src_e, pc_src_e, md_req_e, md_done,
    input  forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
    input  flush_d, flush_e, flush_m, md_start, md_error, stall_count, flush_count
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  regwrite_m, regwrite_w, result_src_e, pc_src_e, md_req_e, md_done,
    output forward_a_e, forward_b_e, stall_f, stall_d, stall_e,
    output flush_d, flush_e, flush_m, md_start, md_error, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
// Purpose : hazard unit for a 5-stage pipeline. Selects operand forwarding for
//           execute, stalls on load-use, flushes on taken branches, and freezes
//           the front of the pipeline while a multi-cycle mul/div runs
//           (IDLE -> MD_BUSY -> MD_DRAIN), with a sticky timeout flag and
//           stall/flush performance counters.
// Params  : MD_TIMEOUT - MD_BUSY cycles without md_done before md_error sets
//           (the busy counter is 7 bits, so 1..128).
// Ports   : clk   - sole clock, rising edge
//           reset - asynchronous, active-high
//           hz    - hazard_if.slave bundle (pipeline info in, controls out)
// -----------------------------------------------------------------------------
module hazard_controller #(
  parameter int MD_TIMEOUT = 64
) (
  input logic    clk,
  input logic    reset,
  hazard_if.slave hz
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MD_BUSY  = 2'd1,
    MD_DRAIN = 2'd2
  } state_t;

  localparam logic [6:0] LP_BUSY_LAST = 7'(MD_TIMEOUT - 1);

  state_t      r_state, w_state_next;
  logic [6:0]  r_busy_cnt;
  logic        r_md_error;
  logic [31:0] r_stall_count, r_flush_count;

  logic w_load_stall, w_timeout, w_md_start;
  logic w_stall_f, w_stall_d, w_stall_e;
  logic w_flush_d, w_flush_e, w_flush_m;

  // Memory-stage match is checked first so the youngest producer wins;
  // x0 is never forwarded since it always reads as zero.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       rw_m, input logic [4:0] rd_m,
                                         input logic       rw_w, input logic [4:0] rd_w);
    if (rw_m && (rd_m != 5'd0) && (rd_m == rs)) return 2'b10;
    if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    return 2'b00;
  endfunction

  assign hz.forward_a_e = fwd_sel(hz.rs1_e, hz.regwrite_m, hz.rd_m, hz.regwrite_w, hz.rd_w);
  assign hz.forward_b_e = fwd_sel(hz.rs2_e, hz.regwrite_m, hz.rd_m, hz.regwrite_w, hz.rd_w);

  assign w_load_stall = (hz.result_src_e == 2'b01) && (hz.rd_e != 5'd0) &&
                        ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

  // A same-cycle md_done beats the timeout, so md_error stays clear.
  assign w_timeout = (r_busy_cnt == LP_BUSY_LAST) && !hz.md_done;

  // Next-state and control decode
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // (an unassigned path in always_comb would infer a latch).
    w_state_next = r_state;
    w_md_start   = 1'b0;
    w_stall_f    = 1'b0;
    w_stall_d    = 1'b0;
    w_stall_e    = 1'b0;
    w_flush_d    = 1'b0;
    w_flush_e    = 1'b0;
    w_flush_m    = 1'b0;
    unique case (r_state)
      IDLE: begin
        // A taken branch squashes decode anyway, so holding it would be wasted.
        w_stall_f = w_load_stall && !hz.pc_src_e;
        w_stall_d = w_load_stall && !hz.pc_src_e;
        w_flush_e = w_load_stall || hz.pc_src_e;
        w_flush_d = hz.pc_src_e;
        if (hz.md_req_e && !hz.pc_src_e) begin
          w_md_start   = 1'b1;
          w_state_next = MD_BUSY;
        end
      end
      MD_BUSY: begin
        // Freeze F/D/E around the mul/div and feed bubbles into memory.
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_e = 1'b1;
        w_flush_m = 1'b1;
        if (hz.md_done || w_timeout) w_state_next = MD_DRAIN;
      end
      MD_DRAIN: w_state_next = IDLE;  // one free cycle lets the result reach memory
      default:  w_state_next = IDLE;
    endcase
  end

  assign hz.stall_f = w_stall_f;
  assign hz.stall_d = w_stall_d;
  assign hz.stall_e = w_stall_e;
  assign hz.flush_d = w_flush_d;
  assign hz.flush_e = w_flush_e;
  assign hz.flush_m = w_flush_m;
  // Reset forces md_start low so a held md_req_e cannot launch an operation
  // while the pipeline is being cleared.
  assign hz.md_start    = w_md_start && !reset;
  assign hz.md_error    = r_md_error;
  assign hz.stall_count = r_stall_count;
  assign hz.flush_count = r_flush_count;

  // FSM state, busy counter and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_busy_cnt <= 7'd0;
      r_md_error <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement or block order.
      r_state <= w_state_next;
      if (r_state == MD_BUSY)            r_busy_cnt <= r_busy_cnt + 7'd1;
      else if (w_state_next == MD_BUSY)  r_busy_cnt <= 7'd0;
      if ((r_state == MD_BUSY) && w_timeout) r_md_error <= 1'b1;
    end
  end

  // Performance counters; natural 32-bit wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= 32'd0;
      r_flush_count <= 32'd0;
    end else begin
      if (w_stall_d) r_stall_count <= r_stall_count + 32'd1;
      if (w_flush_e) r_flush_count <= r_flush_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
// Directed bench for hazard_controller. Expected values are queued when the
// stimulus is applied and popped when the DUT output is sampled (#1 after the
// rising edge, plus settling for combinational paths).
// -----------------------------------------------------------------------------
module tb_hazard_controller;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  hazard_if hz ();

  hazard_controller #(.MD_TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  always #5 clk = ~clk;

  task automatic expect_v(input string tag, input logic [31:0] v);
    sb.push_back('{tag: tag, val: v});
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  // Control vector order: {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m}
  function automatic logic [31:0] ctrl();
    return {26'd0, hz.stall_f, hz.stall_d, hz.stall_e, hz.flush_d, hz.flush_e, hz.flush_m};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz.rs1_d = 5'd0; hz.rs2_d = 5'd0; hz.rs1_e = 5'd0; hz.rs2_e = 5'd0;
    hz.rd_e = 5'd0; hz.rd_m = 5'd0; hz.rd_w = 5'd0;
    hz.regwrite_m = 1'b0; hz.regwrite_w = 1'b0; hz.result_src_e = 2'b00;
    hz.pc_src_e = 1'b0; hz.md_req_e = 1'b0; hz.md_done = 1'b0;
  endtask

  initial begin
    int busy;
    clear_inputs();

    // ---- Reset state, with IDLE decode visible while reset is held ----
    #2;
    expect_v("rst_ctrl", 32'h00); expect_v("rst_stall_cnt", 32'd0);
    expect_v("rst_flush_cnt", 32'd0); expect_v("rst_md_error", 32'd0);
    check(ctrl()); check(hz.stall_count); check(hz.flush_count); check(32'(hz.md_error));
    hz.pc_src_e = 1'b1; hz.md_req_e = 1'b1; #1;
    expect_v("rst_branch_ctrl", 32'b000110); expect_v("rst_md_start", 32'd0);
    check(ctrl()); check(32'(hz.md_start));
    clear_inputs();
    @(negedge clk); reset = 1'b0;
    tick();

    // ---- Forwarding ----
    hz.rd_m = 5'd5; hz.regwrite_m = 1'b1; hz.rd_w = 5'd5; hz.regwrite_w = 1'b1;
    hz.rs1_e = 5'd5; hz.rs2_e = 5'd5; #1;
    expect_v("fwd_a_mem_wins", 32'b10); expect_v("fwd_b_mem_wins", 32'b10);
    check(32'(hz.forward_a_e)); check(32'(hz.forward_b_e));
    hz.rd_m = 5'd0; #1;
    expect_v("fwd_a_wb", 32'b01);
    check(32'(hz.forward_a_e));
    hz.rd_m = 5'd5; hz.rd_w = 5'd9; hz.rs2_e = 5'd9; #1;
    expect_v("fwd_a_mem_split", 32'b10); expect_v("fwd_b_wb_split", 32'b01);
    check(32'(hz.forward_a_e)); check(32'(hz.forward_b_e));
    hz.regwrite_m = 1'b0; hz.regwrite_w = 1'b0; #1;
    expect_v("fwd_a_no_write", 32'b00);
    check(32'(hz.forward_a_e));
    clear_inputs(); hz.regwrite_m = 1'b1; hz.regwrite_w = 1'b1; #1;
    expect_v("fwd_b_x0", 32'b00);
    check(32'(hz.forward_b_e));
    clear_inputs();
    tick();

    // ---- Load-use stall ----
    hz.result_src_e = 2'b01; hz.rd_e = 5'd7; hz.rs2_d = 5'd7; #1;
    expect_v("load_stall_ctrl", 32'b110010);
    check(ctrl());
    tick();
    clear_inputs(); #1;
    expect_v("load_stall_cnt", 32'd1); expect_v("load_flush_cnt", 32'd1); expect_v("after_load_ctrl", 32'h00);
    check(hz.stall_count); check(hz.flush_count); check(ctrl());
    hz.result_src_e = 2'b01; hz.rd_e = 5'd7; hz.rs1_d = 5'd7; hz.pc_src_e = 1'b1; #1;
    expect_v("load_branch_ctrl", 32'b000110);
    check(ctrl());
    tick();
    clear_inputs();
    hz.result_src_e = 2'b01; hz.rd_e = 5'd0; #1;
    expect_v("load_rd_x0_ctrl", 32'h00);
    check(ctrl());
    hz.result_src_e = 2'b10; hz.rd_e = 5'd3; hz.rs1_d = 5'd3; #1;
    expect_v("non_load_ctrl", 32'h00);
    check(ctrl());
    clear_inputs(); #1;
    expect_v("branch_stall_cnt", 32'd1); expect_v("branch_flush_cnt", 32'd2);
    check(hz.stall_count); check(hz.flush_count);
    tick();

    // ---- Mul/div completing after 5 busy cycles ----
    hz.md_req_e = 1'b1; #1;
    expect_v("md_start_pulse", 32'd1); expect_v("md_req_idle_ctrl", 32'h00);
    check(32'(hz.md_start)); check(ctrl());
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 5) begin hz.md_done = 1'b1; hz.pc_src_e = 1'b1; end
      #1;
      expect_v($sformatf("md_busy_ctrl_%0d", i), 32'b111001); expect_v($sformatf("md_busy_start_%0d", i), 32'd0);
      check(ctrl()); check(32'(hz.md_start));
    end
    tick();
    hz.md_done = 1'b0; hz.pc_src_e = 1'b0; #1;
    expect_v("md_drain_ctrl", 32'h00); expect_v("md_drain_start", 32'd0);
    check(ctrl()); check(32'(hz.md_start));
    tick();
    hz.md_req_e = 1'b0;
    hz.md_done = 1'b1; #1;
    expect_v("md_idle_ctrl", 32'h00); expect_v("md_stall_cnt", 32'd6);
    expect_v("md_flush_cnt", 32'd2); expect_v("md_no_error", 32'd0);
    check(ctrl()); check(hz.stall_count); check(hz.flush_count); check(32'(hz.md_error));
    tick();
    hz.md_done = 1'b0; #1;
    expect_v("stray_done_ignored", 32'h00);
    check(ctrl());

    // ---- Mul/div timeout ----
    hz.md_req_e = 1'b1; #1;
    expect_v("tmo_md_start", 32'd1);
    check(32'(hz.md_start));
    tick();
    hz.md_req_e = 1'b0;
    busy = 0;
    while (hz.stall_e && busy < 200) begin
      busy++;
      tick();
    end
    expect_v("tmo_busy_cycles", 32'd64); expect_v("tmo_md_error", 32'd1); expect_v("tmo_drain_ctrl", 32'h00);
    check(32'(busy)); check(32'(hz.md_error)); check(ctrl());
    tick();
    hz.result_src_e = 2'b01; hz.rd_e = 5'd4; hz.rs1_d = 5'd4; #1;
    expect_v("tmo_back_idle_ctrl", 32'b110010); expect_v("tmo_error_sticky", 32'd1);
    expect_v("tmo_stall_cnt", 32'd70);
    check(ctrl()); check(32'(hz.md_error)); check(hz.stall_count);
    clear_inputs();
    tick();

    // ---- Reset during MD_BUSY cycle 3 ----
    hz.md_req_e = 1'b1;
    tick(); tick(); tick();
    expect_v("rb_busy_c3", 32'b111001);
    check(ctrl());
    reset = 1'b1; #1;
    expect_v("rb_ctrl", 32'h00); expect_v("rb_md_error", 32'd0); expect_v("rb_md_start", 32'd0);
    expect_v("rb_stall_cnt", 32'd0); expect_v("rb_flush_cnt", 32'd0);
    check(ctrl()); check(32'(hz.md_error)); check(32'(hz.md_start));
    check(hz.stall_count); check(hz.flush_count);
    hz.md_req_e = 1'b0;
    @(negedge clk); reset = 1'b0;
    tick();
    expect_v("rb_release_start", 32'd0); expect_v("rb_release_ctrl", 32'h00);
    check(32'(hz.md_start)); check(ctrl());
    tick();

    // ---- md_done coinciding with the timeout cycle ----
    hz.md_req_e = 1'b1; #1;
    tick();
    hz.md_req_e = 1'b0;
    for (int i = 0; i < 63; i++) tick();
    hz.md_done = 1'b1; #1;
    expect_v("tie_last_busy_ctrl", 32'b111001);
    check(ctrl());
    tick();
    hz.md_done = 1'b0; #1;
    expect_v("tie_drain_ctrl", 32'h00); expect_v("tie_no_error", 32'd0); expect_v("tie_stall_cnt", 32'd64);
    check(ctrl()); check(32'(hz.md_error)); check(hz.stall_count);
    tick();

    // ---- stall_count wrap ----
    force dut.r_stall_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_count;
    #1;
    expect_v("wrap_preload", 32'hFFFF_FFFF);
    check(hz.stall_count);
    hz.result_src_e = 2'b01; hz.rd_e = 5'd12; hz.rs2_d = 5'd12; #1;
    expect_v("wrap_stall_ctrl", 32'b110010);
    check(ctrl());
    tick();
    clear_inputs(); #1;
    expect_v("wrap_to_zero", 32'd0); expect_v("wrap_flush_cnt", 32'd1);
    check(hz.stall_count); check(hz.flush_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
